// File: rtl/alu_ctrl_pkg.sv
// Shared types and encodings for the multicycle ALU control sequencer.
// Imported by the FSM top and its output decoder.
package alu_ctrl_pkg;

   typedef enum logic [3:0] {
      S_RST, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ADDR, S_MEM_RD,
      S_MDR_OP, S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_EXC
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_BEQ   = 6'h04;

   localparam logic [5:0] F_ADD = 6'h20;
   localparam logic [5:0] F_SUB = 6'h22;
   localparam logic [5:0] F_AND = 6'h24;

   localparam logic [1:0] ALUSRCA_PC  = 2'b00;
   localparam logic [1:0] ALUSRCA_A   = 2'b01;
   localparam logic [1:0] ALUSRCA_B   = 2'b10;
   localparam logic [1:0] ALUSRCA_MDR = 2'b11;

   localparam logic [1:0] ALUSRCB_B      = 2'b00;
   localparam logic [1:0] ALUSRCB_FOUR   = 2'b01;
   localparam logic [1:0] ALUSRCB_IMM    = 2'b10;
   localparam logic [1:0] ALUSRCB_IMM_SH = 2'b11;

   localparam logic [2:0] ALUOP_NONE = 3'b000;
   localparam logic [2:0] ALUOP_ADD  = 3'b001;
   localparam logic [2:0] ALUOP_SUB  = 3'b010;
   localparam logic [2:0] ALUOP_AND  = 3'b011;

   // Supported R-type functions map to an ALU op; anything else is illegal.
   function automatic logic [2:0] funct_to_aluop(input logic [5:0] f);
      case (f)
         F_ADD:   return ALUOP_ADD;
         F_SUB:   return ALUOP_SUB;
         F_AND:   return ALUOP_AND;
         default: return ALUOP_NONE;
      endcase
   endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Moore output decoder: maps the sequencer state to datapath controls,
// with the write enables qualified by mem_ready / zero where needed.
module alu_ctrl_decode
   import alu_ctrl_pkg::*;
(
   input  state_t     state,
   input  logic [5:0] funct,
   input  logic       mem_ready,
   input  logic       zero,
   input  logic       exc_cause,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_op,
   output logic       mem_read,
   output logic       iord,
   output logic       ir_write,
   output logic       pc_write,
   output logic       pc_src,
   output logic       ab_write,
   output logic       alu_out_write,
   output logic       mdr_write,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       exc,
   output logic       exc_code
);

   always_comb begin
      alu_src_a     = ALUSRCA_PC;
      alu_src_b     = ALUSRCB_B;
      alu_op        = ALUOP_NONE;
      mem_read      = 1'b0;
      iord          = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_src        = 1'b0;
      ab_write      = 1'b0;
      alu_out_write = 1'b0;
      mdr_write     = 1'b0;
      reg_write     = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      exc           = 1'b0;
      exc_code      = 1'b0;
      case (state)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = ALUSRCB_FOUR;
            alu_op    = ALUOP_ADD;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         S_DECODE: begin
            ab_write      = 1'b1;
            alu_src_b     = ALUSRCB_IMM_SH;
            alu_op        = ALUOP_ADD;
            alu_out_write = 1'b1;
         end
         S_EXEC_R: begin
            alu_src_a     = ALUSRCA_A;
            alu_op        = funct_to_aluop(funct);
            alu_out_write = 1'b1;
         end
         S_EXEC_I, S_ADDR: begin
            alu_src_a     = ALUSRCA_A;
            alu_src_b     = ALUSRCB_IMM;
            alu_op        = ALUOP_ADD;
            alu_out_write = 1'b1;
         end
         S_MEM_RD: begin
            mem_read  = 1'b1;
            iord      = 1'b1;
            mdr_write = mem_ready;
         end
         S_MDR_OP: begin
            alu_src_a     = ALUSRCA_MDR;
            alu_op        = ALUOP_ADD;
            alu_out_write = 1'b1;
         end
         S_WB_R: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         S_WB_I:   reg_write = 1'b1;
         S_WB_MEM: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a = ALUSRCA_A;
            alu_op    = ALUOP_SUB;
            pc_src    = 1'b1;
            pc_write  = zero;
         end
         S_EXC: begin
            exc      = 1'b1;
            exc_code = exc_cause;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/alu_ctrl_fsm.sv
// Multicycle control sequencer: state register, memory wait-state counter
// and next-state logic; outputs come from alu_ctrl_decode.
module alu_ctrl_fsm
   import alu_ctrl_pkg::*;
#(
   parameter logic [5:0] OP_ADDM      = 6'h30,
   parameter int         MEM_WAIT_MAX = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       mem_ready,
   input  logic       zero,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_op,
   output logic       mem_read,
   output logic       iord,
   output logic       ir_write,
   output logic       pc_write,
   output logic       pc_src,
   output logic       ab_write,
   output logic       alu_out_write,
   output logic       mdr_write,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       exc,
   output logic       exc_code
);

   // The MEM_WAIT_MAX-th consecutive not-ready cycle is the one that times out;
   // ready on that same cycle still completes the access.
   localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT_MAX - 1);

   state_t     state_reg;
   logic [3:0] wait_cnt_reg;
   logic       exc_cause_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= S_RST;
         wait_cnt_reg  <= '0;
         exc_cause_reg <= 1'b0;
      end else begin
         case (state_reg)
            S_RST: state_reg <= S_FETCH;
            S_FETCH, S_MEM_RD: begin
               if (mem_ready) begin
                  wait_cnt_reg <= '0;
                  if (state_reg == S_FETCH)
                     state_reg <= S_DECODE;
                  else if (opcode == OP_ADDM)
                     state_reg <= S_MDR_OP;
                  else
                     state_reg <= S_WB_MEM;
               end else if (wait_cnt_reg == WAIT_LAST) begin
                  wait_cnt_reg  <= '0;
                  exc_cause_reg <= 1'b1;
                  state_reg     <= S_EXC;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + 4'd1;
               end
            end
            S_DECODE: begin
               if (opcode == OP_RTYPE && funct_to_aluop(funct) != ALUOP_NONE)
                  state_reg <= S_EXEC_R;
               else if (opcode == OP_ADDI)
                  state_reg <= S_EXEC_I;
               else if (opcode == OP_LW || opcode == OP_ADDM)
                  state_reg <= S_ADDR;
               else if (opcode == OP_BEQ)
                  state_reg <= S_BRANCH;
               else begin
                  exc_cause_reg <= 1'b0;
                  state_reg     <= S_EXC;
               end
            end
            S_EXEC_R: state_reg <= S_WB_R;
            S_EXEC_I: state_reg <= S_WB_I;
            S_ADDR:   state_reg <= S_MEM_RD;
            S_MDR_OP: state_reg <= S_WB_I;
            default:  state_reg <= S_FETCH;
         endcase
      end
   end

   alu_ctrl_decode u_decode (
      .state         (state_reg),
      .funct         (funct),
      .mem_ready     (mem_ready),
      .zero          (zero),
      .exc_cause     (exc_cause_reg),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .alu_op        (alu_op),
      .mem_read      (mem_read),
      .iord          (iord),
      .ir_write      (ir_write),
      .pc_write      (pc_write),
      .pc_src        (pc_src),
      .ab_write      (ab_write),
      .alu_out_write (alu_out_write),
      .mdr_write     (mdr_write),
      .reg_write     (reg_write),
      .reg_dst       (reg_dst),
      .mem_to_reg    (mem_to_reg),
      .exc           (exc),
      .exc_code      (exc_code)
   );

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Randomized bench for alu_ctrl_fsm: an instruction-level model expands each
// instruction into its expected per-cycle control words.
module tb_alu_ctrl_fsm;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] opcode, funct;
   logic       mem_ready, zero;
   logic [1:0] alu_src_a, alu_src_b;
   logic [2:0] alu_op;
   logic       mem_read, iord, ir_write, pc_write, pc_src, ab_write;
   logic       alu_out_write, mdr_write, reg_write, reg_dst, mem_to_reg;
   logic       exc, exc_code;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   alu_ctrl_fsm dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
      .mem_ready(mem_ready), .zero(zero),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .mem_read(mem_read), .iord(iord), .ir_write(ir_write),
      .pc_write(pc_write), .pc_src(pc_src), .ab_write(ab_write),
      .alu_out_write(alu_out_write), .mdr_write(mdr_write),
      .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .exc(exc), .exc_code(exc_code)
   );

   // Control word flag bits, packed after {src_a, src_b, alu_op}.
   localparam logic [12:0] FL_MR   = 13'h1000;
   localparam logic [12:0] FL_IORD = 13'h0800;
   localparam logic [12:0] FL_IRW  = 13'h0400;
   localparam logic [12:0] FL_PCW  = 13'h0200;
   localparam logic [12:0] FL_PCS  = 13'h0100;
   localparam logic [12:0] FL_ABW  = 13'h0080;
   localparam logic [12:0] FL_AOW  = 13'h0040;
   localparam logic [12:0] FL_MDRW = 13'h0020;
   localparam logic [12:0] FL_RW   = 13'h0010;
   localparam logic [12:0] FL_RD   = 13'h0008;
   localparam logic [12:0] FL_M2R  = 13'h0004;
   localparam logic [12:0] FL_EXC  = 13'h0002;
   localparam logic [12:0] FL_EXCC = 13'h0001;

   function automatic logic [19:0] cw(input logic [1:0] sa, input logic [1:0] sb,
                                      input logic [2:0] op, input logic [12:0] fl);
      return {sa, sb, op, fl};
   endfunction

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic int pick_wait();
      if ($urandom_range(0, 9) < 6) return int'($urandom_range(0, 2));
      return int'($urandom_range(13, 16));
   endfunction

   task automatic check(input string tag, input logic [19:0] got, input logic [19:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %05h expected %05h", tag, got, exp);
      end
   endtask

   // Entered at posedge+1: drive this cycle's inputs, check, advance one clock.
   task automatic run_cycle(input logic [19:0] exp, input logic rdy, input logic z,
                            input string tag);
      mem_ready = rdy;
      zero      = z;
      #1;
      check(tag, {alu_src_a, alu_src_b, alu_op, mem_read, iord, ir_write, pc_write,
                  pc_src, ab_write, alu_out_write, mdr_write, reg_write, reg_dst,
                  mem_to_reg, exc, exc_code}, exp);
      @(posedge clk);
      #1;
   endtask

   // One memory access phase; returns 1 when it timed out into the bus exception.
   task automatic mem_phase(input int w, input logic [12:0] base, input logic [12:0] go,
                            input logic [1:0] sb, input logic [2:0] op,
                            input string tag, output logic timed_out);
      int n;
      n = (w >= 15) ? 15 : w;
      for (int i = 0; i < n; i++)
         run_cycle(cw(2'b00, sb, op, base), 1'b0, rbit(), {tag, "_wait"});
      timed_out = (w >= 15);
      if (timed_out)
         run_cycle(cw(2'b00, 2'b00, 3'b000, FL_EXC | FL_EXCC), rbit(), rbit(), {tag, "_tmo"});
      else
         run_cycle(cw(2'b00, sb, op, base | go), 1'b1, rbit(), {tag, "_go"});
   endtask

   task automatic exec_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int fw, input int mw, input logic bz);
      logic tmo;
      logic [2:0] rop;
      $display("instr op=%02h fn=%02h fetch_wait=%0d mem_wait=%0d zero=%0d", op, fn, fw, mw, bz);
      opcode = op;
      funct  = fn;
      mem_phase(fw, FL_MR, FL_IRW | FL_PCW, 2'b01, 3'b001, "fetch", tmo);
      if (tmo) return;
      run_cycle(cw(2'b00, 2'b11, 3'b001, FL_ABW | FL_AOW), rbit(), rbit(), "decode");
      rop = (fn == 6'h20) ? 3'b001 : (fn == 6'h22) ? 3'b010 : (fn == 6'h24) ? 3'b011 : 3'b000;
      if (op == 6'h00 && rop != 3'b000) begin
         run_cycle(cw(2'b01, 2'b00, rop, FL_AOW), rbit(), rbit(), "exec_r");
         run_cycle(cw(2'b00, 2'b00, 3'b000, FL_RW | FL_RD), rbit(), rbit(), "wb_r");
      end else if (op == 6'h08) begin
         run_cycle(cw(2'b01, 2'b10, 3'b001, FL_AOW), rbit(), rbit(), "exec_i");
         run_cycle(cw(2'b00, 2'b00, 3'b000, FL_RW), rbit(), rbit(), "wb_i");
      end else if (op == 6'h23 || op == 6'h30) begin
         run_cycle(cw(2'b01, 2'b10, 3'b001, FL_AOW), rbit(), rbit(), "addr");
         mem_phase(mw, FL_MR | FL_IORD, FL_MDRW, 2'b00, 3'b000, "mem_rd", tmo);
         if (tmo) return;
         if (op == 6'h23) begin
            run_cycle(cw(2'b00, 2'b00, 3'b000, FL_RW | FL_M2R), rbit(), rbit(), "wb_mem");
         end else begin
            run_cycle(cw(2'b11, 2'b00, 3'b001, FL_AOW), rbit(), rbit(), "mdr_op");
            run_cycle(cw(2'b00, 2'b00, 3'b000, FL_RW), rbit(), rbit(), "wb_i_addm");
         end
      end else if (op == 6'h04) begin
         run_cycle(cw(2'b01, 2'b00, 3'b010, FL_PCS | (bz ? FL_PCW : 13'h0)), rbit(), bz, "branch");
      end else begin
         run_cycle(cw(2'b00, 2'b00, 3'b000, FL_EXC), rbit(), rbit(), "exc_illegal");
      end
   endtask

   initial begin
      logic [5:0] op, fn;
      logic [5:0] ops [6];
      logic [5:0] fns [3];
      ops[0] = 6'h00; ops[1] = 6'h08; ops[2] = 6'h23;
      ops[3] = 6'h30; ops[4] = 6'h04; ops[5] = 6'h3F;
      fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h24;
      reset = 1'b1; opcode = '0; funct = '0; mem_ready = 1'b0; zero = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      run_cycle(20'h0, rbit(), rbit(), "rst_state");

      // Reset asserted while in ADDR of a lw.
      $display("instr op=23 reset during ADDR");
      opcode = 6'h23; funct = 6'h00;
      run_cycle(cw(2'b00, 2'b01, 3'b001, FL_MR | FL_IRW | FL_PCW), 1'b1, 1'b0, "fetch_go");
      run_cycle(cw(2'b00, 2'b11, 3'b001, FL_ABW | FL_AOW), 1'b0, 1'b0, "decode");
      reset = 1'b1;
      run_cycle(cw(2'b01, 2'b10, 3'b001, FL_AOW), 1'b0, 1'b0, "addr_before_rst");
      reset = 1'b0;
      run_cycle(20'h0, 1'b1, 1'b1, "rst_mid_addr");

      exec_instr(6'h00, 6'h20, 0, 0, 1'b0);
      exec_instr(6'h30, 6'h00, 0, 3, 1'b0);
      exec_instr(6'h04, 6'h00, 0, 0, 1'b1);
      exec_instr(6'h04, 6'h00, 0, 0, 1'b0);
      exec_instr(6'h3F, 6'h20, 0, 0, 1'b0);
      exec_instr(6'h00, 6'h21, 0, 0, 1'b0);
      exec_instr(6'h08, 6'h00, 15, 0, 1'b0);
      exec_instr(6'h08, 6'h00, 14, 0, 1'b0);
      exec_instr(6'h23, 6'h00, 1, 14, 1'b0);
      exec_instr(6'h23, 6'h00, 0, 15, 1'b0);

      for (int k = 0; k < 200; k++) begin
         op = ops[$urandom_range(0, 5)];
         if ($urandom_range(0, 7) == 0) op = 6'($urandom_range(0, 63));
         fn = fns[$urandom_range(0, 2)];
         if ($urandom_range(0, 7) == 0) fn = 6'($urandom_range(0, 63));
         exec_instr(op, fn, pick_wait(), pick_wait(), rbit());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
